// File: rtl/doodle_pkg.sv
// Shared screen geometry and one-hot jump-state encodings for the doodle blocks.
package doodle_pkg;

   // Visible-area offsets and resolution of the VGA timing.
   localparam int X_OFFSET      = 144;
   localparam int Y_OFFSET      = 35;
   localparam int H_RES         = 640;
   localparam int V_RES         = 480;
   localparam int V_MIDDLE      = Y_OFFSET + V_RES / 2;
   localparam int DOODLE_RADIUS = 10;

   // One-hot encodings shared with doodle_sm, packed as {Done, Down, Up, I}.
   typedef enum logic [3:0] {
      ST_I    = 4'b0001,
      ST_UP   = 4'b0010,
      ST_DOWN = 4'b0100,
      ST_DONE = 4'b1000
   } doodle_state_t;

   // Anything that is not exactly one-hot freezes the doodle like DONE.
   function automatic doodle_state_t decode_state(input logic [3:0] vec);
      doodle_state_t st;
      case (vec)
         4'b0001: st = ST_I;
         4'b0010: st = ST_UP;
         4'b0100: st = ST_DOWN;
         default: st = ST_DONE;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Game-tick divider: a registered one-cycle pulse every TICK_DIV clocks, plus
// the combinational terminal-count flag so callers can update on the same edge.
module tick_gen #(
   parameter int TICK_DIV = 500000
) (
   input  logic Clk,
   input  logic Reset_n,
   output logic tick,
   output logic wrap
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] count;

   assign wrap = (count == CW'(TICK_DIV - 1));

   // Free-running divider; the pulse is registered on the terminal-count edge.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (wrap) begin
         count <= '0;
         tick  <= 1'b1;
      end else begin
         count <= count + CW'(1);
         tick  <= 1'b0;
      end
   end

endmodule

// File: rtl/doodle_motion.sv
// Doodle motion integrator: turns the one-hot jump state and the left/right
// buttons into a screen position, updated once per game tick.
module doodle_motion
   import doodle_pkg::*;
#(
   parameter int TICK_DIV    = 500000,
   parameter int X_MIN       = X_OFFSET,
   parameter int X_MAX       = X_OFFSET + H_RES - DOODLE_RADIUS,
   parameter int Y_MIN       = Y_OFFSET,
   parameter int X_START     = 459,
   parameter int Y_START     = 480,
   parameter int H_STEP      = 2,
   parameter int MAX_SPEED   = 8,
   parameter int UP_SHIFT    = 4,
   parameter int ACCEL_TICKS = 4
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        q_I,
   input  logic        q_Up,
   input  logic        q_Down,
   input  logic        q_Done,
   input  logic        is_in_middle,
   input  logic        BtnL,
   input  logic        BtnR,
   output logic [15:0] object_x,
   output logic [15:0] object_y,
   output logic [9:0]  up_count,
   output logic [3:0]  vert_speed,
   output logic        tick
);

   localparam int FCW = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

   logic            wrap;
   doodle_state_t   state;
   logic [FCW-1:0]  fall_count;
   logic [3:0]      fall_speed;
   logic [3:0]      up_speed;
   int              up_speed_int;
   logic [10:0]     up_sum;
   logic [9:0]      up_count_next;
   logic [15:0]     y_up;
   logic [16:0]     y_sum;
   logic [15:0]     y_down;
   logic [15:0]     x_next;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .tick    (tick),
      .wrap    (wrap)
   );

   assign state = decode_state({q_Done, q_Down, q_Up, q_I});

   // Rising speed decays with distance risen; never drops below one pixel.
   always_comb begin
      up_speed_int = MAX_SPEED - int'(up_count >> UP_SHIFT);
      if (up_speed_int < 1) begin
         up_speed_int = 1;
      end
      up_speed      = 4'(up_speed_int);
      up_sum        = {1'b0, up_count} + 11'(up_speed);
      up_count_next = (up_sum > 11'h3FF) ? 10'h3FF : up_sum[9:0];
   end

   // Candidate vertical positions: clamp at the top when rising, saturate when falling.
   always_comb begin
      if (int'(object_y) - int'(up_speed) < Y_MIN) begin
         y_up = 16'(Y_MIN);
      end else begin
         y_up = object_y - 16'(up_speed);
      end
      y_sum  = {1'b0, object_y} + 17'(fall_speed);
      y_down = y_sum[16] ? 16'hFFFF : y_sum[15:0];
   end

   // Horizontal step with wrap-around; both or neither button holds x.
   always_comb begin
      x_next = object_x;
      if (BtnL && !BtnR) begin
         if (int'(object_x) - H_STEP < X_MIN) begin
            x_next = 16'(X_MAX);
         end else begin
            x_next = object_x - 16'(H_STEP);
         end
      end else if (BtnR && !BtnL) begin
         if (int'(object_x) + H_STEP > X_MAX) begin
            x_next = 16'(X_MIN);
         end else begin
            x_next = object_x + 16'(H_STEP);
         end
      end
   end

   // Per-tick motion update, followed by the per-cycle clears that prime each jump phase.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         object_x   <= 16'(X_START);
         object_y   <= 16'(Y_START);
         up_count   <= '0;
         vert_speed <= 4'(MAX_SPEED);
         fall_count <= '0;
         fall_speed <= 4'd1;
      end else begin
         if (wrap) begin
            case (state)
               ST_I: begin
                  object_x   <= 16'(X_START);
                  object_y   <= 16'(Y_START);
                  vert_speed <= 4'(MAX_SPEED);
               end
               ST_UP: begin
                  vert_speed <= up_speed;
                  up_count   <= up_count_next;
                  object_x   <= x_next;
                  if (!is_in_middle) begin
                     object_y <= y_up;
                  end
               end
               ST_DOWN: begin
                  vert_speed <= fall_speed;
                  object_y   <= y_down;
                  object_x   <= x_next;
                  if (fall_count == FCW'(ACCEL_TICKS - 1)) begin
                     fall_count <= '0;
                     if (fall_speed < 4'(MAX_SPEED)) begin
                        fall_speed <= fall_speed + 4'd1;
                     end
                  end else begin
                     fall_count <= fall_count + FCW'(1);
                  end
               end
               default: begin
                  // DONE or a non-one-hot state: everything holds.
               end
            endcase
         end
         // Leaving a phase rearms it, so a bounce always restarts at full rise speed.
         if (!q_Up) begin
            up_count <= '0;
         end
         if (!q_Down) begin
            fall_count <= '0;
            fall_speed <= 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_doodle_motion.sv
// Directed bench for doodle_motion with a 4-cycle game tick.
module tb_doodle_motion;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        q_I, q_Up, q_Down, q_Done;
   logic        is_in_middle, BtnL, BtnR;
   logic [15:0] object_x, object_y;
   logic [9:0]  up_count;
   logic [3:0]  vert_speed;
   logic        tick;

   int n_cmp = 0;
   int n_bad = 0;

   doodle_motion #(
      .TICK_DIV  (4),
      .MAX_SPEED (8)
   ) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .q_I          (q_I),
      .q_Up         (q_Up),
      .q_Down       (q_Down),
      .q_Done       (q_Done),
      .is_in_middle (is_in_middle),
      .BtnL         (BtnL),
      .BtnR         (BtnR),
      .object_x     (object_x),
      .object_y     (object_y),
      .up_count     (up_count),
      .vert_speed   (vert_speed),
      .tick         (tick)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_state(input logic i, input logic u, input logic d, input logic dn);
      q_I = i; q_Up = u; q_Down = d; q_Done = dn;
   endtask

   // Waits (bounded) for the next tick pulse; returns the number of cycles taken.
   task automatic wait_tick(output int cycles);
      cycles = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge Clk);
         if (tick === 1'b1) begin
            cycles = k;
            break;
         end
      end
      if (cycles == 0) begin
         chk("tick_timeout", 32'd0, 32'd1);
      end
   endtask

   initial begin
      int n;
      int exp_spd;
      int exp_y;

      Reset_n = 1'b0;
      set_state(1, 0, 0, 0);
      is_in_middle = 1'b0; BtnL = 1'b0; BtnR = 1'b0;
      repeat (2) @(negedge Clk);
      chk("reset_x", object_x, 459);
      chk("reset_y", object_y, 480);
      chk("reset_up_count", up_count, 0);
      chk("reset_speed", vert_speed, 8);
      chk("reset_tick", tick, 0);
      Reset_n = 1'b1;
      wait_tick(n);
      chk("first_tick_latency", n, 4);
      @(negedge Clk);
      chk("tick_one_cycle", tick, 0);
      $display("step: reset and first tick checked");

      // Rise with deceleration
      set_state(0, 1, 0, 0);
      wait_tick(n);
      chk("rise1_y", object_y, 472); chk("rise1_uc", up_count, 8); chk("rise1_spd", vert_speed, 8);
      wait_tick(n);
      chk("rise2_y", object_y, 464); chk("rise2_uc", up_count, 16); chk("rise2_spd", vert_speed, 8);
      wait_tick(n);
      chk("rise3_y", object_y, 457); chk("rise3_uc", up_count, 23); chk("rise3_spd", vert_speed, 7);
      $display("step: rise with deceleration checked");

      // Scroll hold: y frozen, up_count keeps integrating
      is_in_middle = 1'b1;
      wait_tick(n);
      chk("scroll1_y", object_y, 457); chk("scroll1_uc", up_count, 30);
      wait_tick(n);
      chk("scroll2_y", object_y, 457); chk("scroll2_uc", up_count, 37);
      wait_tick(n);
      chk("scroll3_y", object_y, 457); chk("scroll3_uc", up_count, 43); chk("scroll3_spd", vert_speed, 6);
      $display("step: scroll hold checked");

      // Reset mid-jump
      Reset_n = 1'b0;
      @(negedge Clk);
      chk("midreset_x", object_x, 459); chk("midreset_y", object_y, 480);
      chk("midreset_uc", up_count, 0); chk("midreset_spd", vert_speed, 8);
      Reset_n = 1'b1;
      wait_tick(n);
      chk("midreset_latency", n, 4);
      chk("midreset_tick_uc", up_count, 8);
      chk("midreset_tick_y", object_y, 480);
      $display("step: reset mid-jump checked");

      // Fall acceleration
      set_state(0, 0, 1, 0);
      is_in_middle = 1'b0;
      exp_y = 480;
      for (int k = 1; k <= 34; k++) begin
         wait_tick(n);
         exp_spd = (k - 1) / 4 + 1;
         if (exp_spd > 8) exp_spd = 8;
         exp_y += exp_spd;
         chk("fall_spd", vert_speed, exp_spd);
         chk("fall_y", object_y, exp_y);
      end
      chk("fall_end_y", object_y, 640);
      chk("fall_uc", up_count, 0);
      $display("step: fall acceleration checked");

      // Bounce: DOWN -> UP restarts at full speed
      set_state(0, 1, 0, 0);
      wait_tick(n);
      chk("bounce1_spd", vert_speed, 8); chk("bounce1_uc", up_count, 8); chk("bounce1_y", object_y, 632);
      wait_tick(n);
      chk("bounce2_uc", up_count, 16); chk("bounce2_y", object_y, 624);
      set_state(0, 0, 1, 0);
      @(negedge Clk);
      chk("uc_clear_latency", up_count, 0);
      wait_tick(n);
      chk("redown_spd", vert_speed, 1); chk("redown_y", object_y, 625);
      $display("step: bounce clear checked");

      // Horizontal wrap to the left edge via BtnR
      set_state(1, 0, 0, 0);
      wait_tick(n);
      chk("idle_x", object_x, 459); chk("idle_y", object_y, 480); chk("idle_spd", vert_speed, 8);
      set_state(0, 1, 0, 0);
      is_in_middle = 1'b1;
      BtnR = 1'b1;
      for (int k = 0; k < 157; k++) wait_tick(n);
      chk("right_run_x", object_x, 773);
      wait_tick(n);
      chk("right_wrap_x", object_x, 144);
      $display("step: right wrap checked");

      // Horizontal wrap to the right edge via BtnL
      BtnR = 1'b0;
      set_state(1, 0, 0, 0);
      wait_tick(n);
      chk("idle2_x", object_x, 459);
      set_state(0, 1, 0, 0);
      BtnL = 1'b1;
      for (int k = 0; k < 157; k++) wait_tick(n);
      chk("left_run_x", object_x, 145);
      wait_tick(n);
      chk("left_wrap_x", object_x, 774);
      BtnR = 1'b1;
      wait_tick(n);
      chk("both_btn_x", object_x, 774);
      BtnL = 1'b0; BtnR = 1'b0;
      wait_tick(n);
      chk("no_btn_x", object_x, 774);
      chk("held_y", object_y, 480);
      chk("min_spd", vert_speed, 1);
      $display("step: left wrap and button combos checked");

      // DONE freeze, then a non-one-hot state
      set_state(0, 0, 0, 1);
      is_in_middle = 1'b0;
      BtnR = 1'b1;
      for (int k = 0; k < 10; k++) begin
         wait_tick(n);
         chk("done_x", object_x, 774); chk("done_y", object_y, 480);
         chk("done_spd", vert_speed, 1); chk("done_uc", up_count, 0);
      end
      set_state(0, 1, 1, 0);
      for (int k = 0; k < 2; k++) begin
         wait_tick(n);
         chk("illegal_x", object_x, 774); chk("illegal_y", object_y, 480);
         chk("illegal_spd", vert_speed, 1);
      end
      set_state(1, 0, 0, 0);
      BtnR = 1'b0;
      wait_tick(n);
      chk("return_idle_x", object_x, 459); chk("return_idle_spd", vert_speed, 8);
      $display("step: freeze and return to idle checked");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
